// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants, FSM state type and sizing helper for the nibble-serial adder.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } adder_state_t;

  function automatic int nibbles_for(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The sub_in signal exists only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 32
);

  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             carry_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic             sub_in;
`endif

  modport master (
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    output sub_in,
`endif
    output valid_in, a_in, b_in, carry_in, ready_in,
    input  ready_out, valid_out, sum, carry_out, busy
  );

  modport slave (
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  sub_in,
`endif
    input  valid_in, a_in, b_in, carry_in, ready_in,
    output ready_out, valid_out, sum, carry_out, busy
  );

endinterface

// File: rtl/nibble_serial_adder_adder4.sv
// The existing 4-bit adder used as the per-nibble datapath.
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one adder4 over WIDTH/4 cycles, LSB nibble first.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to add a sub_in control computing a + ~b + 1.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  nibble_serial_adder_if.slave  bus
);

  localparam int NIBBLES = nibbles_for(WIDTH);
  localparam int CNT_W   = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  adder_state_t         state;
  adder_state_t         state_nxt;
  logic [WIDTH-1:0]     a_lat;
  logic [WIDTH-1:0]     b_lat;
  logic [WIDTH-1:0]     sum_r;
  logic                 carry_r;
  logic                 cout_r;
  logic [CNT_W-1:0]     cnt;
  logic [NIBBLE_W-1:0]  a_nib;
  logic [NIBBLE_W-1:0]  b_nib;
  logic [NIBBLE_W-1:0]  s_nib;
  logic                 c_nib;
  logic                 accept;
  logic                 last;

  assign accept = (state == IDLE) && bus.valid_in;
  assign last   = (cnt == LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.valid_in) state_nxt = CALC;
      CALC:    if (last)         state_nxt = DONE;
      DONE:    if (bus.ready_in) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_out = (state == IDLE);
    bus.valid_out = (state == DONE);
    bus.busy      = (state != IDLE);
  end

  assign bus.sum       = sum_r;
  assign bus.carry_out = cout_r;

  assign a_nib = a_lat[NIBBLE_W*cnt +: NIBBLE_W];

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic sub_lat;
  // Subtraction inverts B as it is consumed; the forced carry-in supplies the +1.
  assign b_nib = b_lat[NIBBLE_W*cnt +: NIBBLE_W] ^ {NIBBLE_W{sub_lat}};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)   sub_lat <= 1'b0;
    else if (accept) sub_lat <= bus.sub_in;
  end
`else
  assign b_nib = b_lat[NIBBLE_W*cnt +: NIBBLE_W];
`endif

  adder4 u_adder4 (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_r),
    .s    (s_nib),
    .cout (c_nib)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_lat   <= '0;
      b_lat   <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_lat   <= bus.a_in;
      b_lat   <= bus.b_in;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      carry_r <= bus.sub_in | bus.carry_in;
`else
      carry_r <= bus.carry_in;
`endif
      sum_r   <= '0;
      cnt     <= '0;
    end else if (state == CALC) begin
      sum_r[NIBBLE_W*cnt +: NIBBLE_W] <= s_nib;
      carry_r <= c_nib;
      cnt     <= cnt + 1'b1;
      if (last) cout_r <= c_nib;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=32 and WIDTH=8.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   tests  = 0;
  int   failed = 0;

  nibble_serial_adder_if #(.WIDTH(32)) b32 ();
  nibble_serial_adder_if #(.WIDTH(8))  b8 ();

  nibble_serial_adder #(.WIDTH(32)) dut32 (.clk_in(clk), .rst_n_in(rst_n), .bus(b32.slave));
  nibble_serial_adder #(.WIDTH(8))  dut8  (.clk_in(clk), .rst_n_in(rst_n), .bus(b8.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic [32:0] exp);
    int lat;
    @(negedge clk);
    b32.a_in = a; b32.b_in = b; b32.carry_in = cin; b32.valid_in = 1'b1; b32.ready_in = 1'b1;
    @(posedge clk); #1;
    b32.valid_in = 1'b0;
    lat = 0;
    while (b32.valid_out !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd8);
    chk({tag, " result"}, 64'({b32.carry_out, b32.sum}), 64'(exp));
    @(posedge clk); #1;
    chk({tag, " back_idle"}, 64'({b32.ready_out, b32.valid_out, b32.busy}), 64'b100);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic [8:0] exp);
    int lat;
    @(negedge clk);
    b8.a_in = a; b8.b_in = b; b8.carry_in = cin; b8.valid_in = 1'b1; b8.ready_in = 1'b1;
    @(posedge clk); #1;
    b8.valid_in = 1'b0;
    lat = 0;
    while (b8.valid_out !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd2);
    chk({tag, " result"}, 64'({b8.carry_out, b8.sum}), 64'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bl [4];
    logic [8:0] e8;
    int         lat;

    rst_n = 1'b0;
    b32.valid_in = 1'b0; b32.ready_in = 1'b1; b32.a_in = '0; b32.b_in = '0; b32.carry_in = 1'b0;
    b8.valid_in  = 1'b0; b8.ready_in  = 1'b1; b8.a_in  = '0; b8.b_in  = '0; b8.carry_in  = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    b32.sub_in = 1'b0;
    b8.sub_in  = 1'b0;
`endif
    #3;
    chk("reset32", 64'({b32.sum, b32.carry_out, b32.valid_out, b32.busy, b32.ready_out}), 64'h1);
    chk("reset8",  64'({b8.sum, b8.carry_out, b8.valid_out, b8.busy, b8.ready_out}), 64'h1);
    #9 rst_n = 1'b1;

    op32("basic",  32'h0000_0003, 32'h0000_0004, 1'b0, 33'h0_0000_0007);
    op32("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
    op32("wrap",   32'h8000_0000, 32'h8000_0001, 1'b0, 33'h1_0000_0001);

    // Backpressure: result must hold while new operands are offered and ignored.
    @(negedge clk);
    b32.a_in = 32'h0000_00FF; b32.b_in = 32'h0000_0001; b32.carry_in = 1'b0;
    b32.valid_in = 1'b1; b32.ready_in = 1'b0;
    @(posedge clk); #1;
    b32.valid_in = 1'b0;
    lat = 0;
    while (b32.valid_out !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b32.valid_in = 1'b1; b32.a_in = $urandom; b32.b_in = $urandom; b32.carry_in = 1'b1;
      @(posedge clk); #1;
      chk("bp hold", 64'({b32.carry_out, b32.sum, b32.valid_out, b32.ready_out, b32.busy}),
          64'({1'b0, 32'h0000_0100, 3'b101}));
    end
    @(negedge clk);
    b32.valid_in = 1'b0; b32.ready_in = 1'b1;
    @(posedge clk); #1;
    chk("bp release", 64'({b32.ready_out, b32.valid_out, b32.busy}), 64'b100);
    @(posedge clk); #1;
    chk("bp no_queue", 64'({b32.ready_out, b32.busy}), 64'b10);

    // Asynchronous reset part-way through CALC.
    @(negedge clk);
    b32.a_in = 32'h1111_1111; b32.b_in = 32'h2222_2222; b32.carry_in = 1'b0; b32.valid_in = 1'b1;
    @(posedge clk); #1;
    b32.valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("partial", 64'(b32.sum), 64'h0000_3333);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset", 64'({b32.sum, b32.carry_out, b32.valid_out, b32.ready_out, b32.busy}), 64'b10);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_result", 64'({b32.valid_out, b32.ready_out, b32.busy}), 64'b010);
    op32("after_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789);

    // WIDTH=8 sweep: every A against a set of B patterns, both carry-ins.
    for (int a = 0; a < 256; a++) begin
      bl[0] = 8'(a); bl[1] = 8'hFF; bl[2] = 8'h01; bl[3] = ~8'(a);
      for (int j = 0; j < 4; j++) begin
        for (int c = 0; c < 2; c++) begin
          e8 = {1'b0, 8'(a)} + {1'b0, bl[j]} + 9'(c);
          op8("w8", 8'(a), bl[j], 1'(c), e8);
        end
      end
    end

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    b8.sub_in = 1'b1;
    op8("sub 5-7", 8'd5, 8'd7, 1'b0, 9'h0FE);
    op8("sub 7-5", 8'd7, 8'd5, 1'b0, 9'h102);
    b8.sub_in = 1'b0;
    op8("add after sub", 8'd5, 8'd7, 1'b1, 9'h00D);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
